eth_rx_header_filter: RTL and testbench

- Receive-side counterpart to the transmit Ethernet helper stage.
- Consumes a 64-bit AXI-Stream Ethernet frame (from a MAC RX path or a loopback of the helper's output) and checks its 16-byte header: Destination (6 B), Source (6 B), Link_Type (2 B), SyncWord (2 B).
- On match, strips the header and forwards only the payload with correct tkeep/tlast.
- Non-matching and runt frames are discarded whole; each outcome increments a status counter.

---
 rtl/eth_rx_header_filter.sv | 161 ++++++++++++++++
 tb/tb_eth_rx_header_filter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_header_filter.sv
// Receive-side Ethernet header filter: checks the 16-byte header of each 64-bit
// AXI-Stream frame and forwards only the payload of frames addressed to us.
module eth_rx_header_filter #(
    parameter int DATA_WIDTH    = 64,
    parameter int COUNTER_WIDTH = 32,
    parameter bit CHECK_SYNC    = 1'b1
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [DATA_WIDTH-1:0]    S_AXIS_tdata,
    input  logic [DATA_WIDTH/8-1:0]  S_AXIS_tkeep,
    input  logic                     S_AXIS_tvalid,
    input  logic                     S_AXIS_tlast,
    output logic                     S_AXIS_tready,
    output logic [DATA_WIDTH-1:0]    M_AXIS_tdata,
    output logic [DATA_WIDTH/8-1:0]  M_AXIS_tkeep,
    output logic                     M_AXIS_tvalid,
    output logic                     M_AXIS_tlast,
    input  logic                     M_AXIS_tready,
    input  logic [47:0]              Destination_Address,
    input  logic [15:0]              Link_Type,
    input  logic [15:0]              SyncWord,
    input  logic                     Accept_Broadcast,
    output logic [COUNTER_WIDTH-1:0] Frames_Accepted,
    output logic [COUNTER_WIDTH-1:0] Frames_Dropped
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam logic [KEEP_WIDTH-1:0] KEEP_ALL = '1;
    localparam logic [47:0] BROADCAST = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        HDR0,
        HDR1,
        PAYLOAD,
        DROP
    } state_t;

    state_t state;
    state_t state_next;

    logic        in_xfer;
    logic        out_load;
    logic        beat_full;
    logic        dest_match_beat;
    logic        dest_match_q;
    logic        hdr_match;
    logic        inc_accepted;
    logic        inc_dropped;
    logic [47:0] beat_dest;
    logic [15:0] beat_link_type;
    logic [15:0] beat_sync;

    // Header fields arrive in network order: byte 0 of a beat is the most significant.
    assign beat_dest = {S_AXIS_tdata[7:0],   S_AXIS_tdata[15:8],  S_AXIS_tdata[23:16],
                        S_AXIS_tdata[31:24], S_AXIS_tdata[39:32], S_AXIS_tdata[47:40]};
    assign beat_link_type = {S_AXIS_tdata[39:32], S_AXIS_tdata[47:40]};
    assign beat_sync      = {S_AXIS_tdata[55:48], S_AXIS_tdata[63:56]};

    assign beat_full       = (S_AXIS_tkeep == KEEP_ALL);
    assign dest_match_beat = (beat_dest == Destination_Address) ||
                             (Accept_Broadcast && (beat_dest == BROADCAST));
    assign hdr_match       = dest_match_q && (beat_link_type == Link_Type) &&
                             (!CHECK_SYNC || (beat_sync == SyncWord));

    assign S_AXIS_tready = (state == PAYLOAD) ? (!M_AXIS_tvalid || M_AXIS_tready) : 1'b1;
    assign in_xfer       = S_AXIS_tvalid && S_AXIS_tready;
    assign out_load      = in_xfer && (state == PAYLOAD);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= HDR0;
            dest_match_q <= 1'b0;
        end else begin
            state <= state_next;
            if (in_xfer && (state == HDR0)) begin
                dest_match_q <= dest_match_beat;
            end
        end
    end

    // Each frame reaches exactly one counting decision, so the two counters never fire together.
    always_comb begin
        state_next   = state;
        inc_accepted = 1'b0;
        inc_dropped  = 1'b0;
        case (state)
            HDR0: begin
                if (in_xfer) begin
                    if (S_AXIS_tlast || !beat_full) begin
                        inc_dropped = 1'b1;
                        state_next  = S_AXIS_tlast ? HDR0 : DROP;
                    end else begin
                        state_next = HDR1;
                    end
                end
            end
            HDR1: begin
                if (in_xfer) begin
                    if (!beat_full) begin
                        inc_dropped = 1'b1;
                        state_next  = S_AXIS_tlast ? HDR0 : DROP;
                    end else if (S_AXIS_tlast) begin
                        inc_dropped = 1'b1;
                        state_next  = HDR0;
                    end else if (!hdr_match) begin
                        inc_dropped = 1'b1;
                        state_next  = DROP;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (in_xfer && S_AXIS_tlast) begin
                    inc_accepted = 1'b1;
                    state_next   = HDR0;
                end
            end
            DROP: begin
                if (in_xfer && S_AXIS_tlast) begin
                    state_next = HDR0;
                end
            end
            default: begin
                state_next = HDR0;
            end
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            M_AXIS_tvalid <= 1'b0;
            M_AXIS_tdata  <= '0;
            M_AXIS_tkeep  <= '0;
            M_AXIS_tlast  <= 1'b0;
        end else if (out_load) begin
            M_AXIS_tvalid <= 1'b1;
            M_AXIS_tdata  <= S_AXIS_tdata;
            M_AXIS_tkeep  <= S_AXIS_tkeep;
            M_AXIS_tlast  <= S_AXIS_tlast;
        end else if (M_AXIS_tready) begin
            M_AXIS_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            Frames_Accepted <= '0;
            Frames_Dropped  <= '0;
        end else begin
            if (inc_accepted) begin
                Frames_Accepted <= Frames_Accepted + COUNTER_WIDTH'(1);
            end
            if (inc_dropped) begin
                Frames_Dropped <= Frames_Dropped + COUNTER_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_eth_rx_header_filter.sv
// Self-checking bench for eth_rx_header_filter: directed frames plus randomized traffic
// compared against a frame-level reference model, for both CHECK_SYNC settings.
module tb_eth_rx_header_filter;

    localparam int CW = 32;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic [63:0]   s_data = '0;
    logic [7:0]    s_keep = '0;
    logic          s_valid = 1'b0;
    logic          s_last = 1'b0;
    logic          s_ready, s_ready2, s_valid2;
    logic [63:0]   m_data, m2_data;
    logic [7:0]    m_keep, m2_keep;
    logic          m_valid, m2_valid, m_last, m2_last;
    logic          m_ready = 1'b1;
    logic [47:0]   cfg_dest = '0;
    logic [15:0]   cfg_lt = '0;
    logic [15:0]   cfg_sync = '0;
    logic          cfg_bcast = 1'b0;
    logic [CW-1:0] acc1, drop1, acc2, drop2;

    int unsigned   vectors = 0;
    int unsigned   miscompares = 0;
    beat_t         frame_q[$];
    beat_t         exp_q1[$];
    beat_t         exp_q2[$];
    logic [CW-1:0] exp_acc1 = '0, exp_drop1 = '0, exp_acc2 = '0, exp_drop2 = '0;
    int            cyc = 0;
    int            beat2_cyc = 0;
    int            rise_cyc = -1;
    int            out1_count = 0;
    int            gap_pct = 0;
    int            m_mode = 0;
    int            pat_idx = 0;
    logic [3:0]    ready_pat = 4'b1001;
    bit            check_ready_drop = 1'b0;
    bit            prev_hold = 1'b0;
    bit            prev_valid = 1'b0;
    logic [72:0]   prev_word = '0;

    localparam logic [47:0] OWN_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC_MAC = 48'h02_11_22_33_44_55;

    // Second instance ignores SyncWord; it sees exactly the transfers the first one accepts.
    assign s_valid2 = s_valid && s_ready;

    eth_rx_header_filter #(.DATA_WIDTH(64), .COUNTER_WIDTH(CW), .CHECK_SYNC(1'b1)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(s_data), .S_AXIS_tkeep(s_keep), .S_AXIS_tvalid(s_valid),
        .S_AXIS_tlast(s_last), .S_AXIS_tready(s_ready),
        .M_AXIS_tdata(m_data), .M_AXIS_tkeep(m_keep), .M_AXIS_tvalid(m_valid),
        .M_AXIS_tlast(m_last), .M_AXIS_tready(m_ready),
        .Destination_Address(cfg_dest), .Link_Type(cfg_lt), .SyncWord(cfg_sync),
        .Accept_Broadcast(cfg_bcast), .Frames_Accepted(acc1), .Frames_Dropped(drop1)
    );

    eth_rx_header_filter #(.DATA_WIDTH(64), .COUNTER_WIDTH(CW), .CHECK_SYNC(1'b0)) dut_nosync (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(s_data), .S_AXIS_tkeep(s_keep), .S_AXIS_tvalid(s_valid2),
        .S_AXIS_tlast(s_last), .S_AXIS_tready(s_ready2),
        .M_AXIS_tdata(m2_data), .M_AXIS_tkeep(m2_keep), .M_AXIS_tvalid(m2_valid),
        .M_AXIS_tlast(m2_last), .M_AXIS_tready(1'b1),
        .Destination_Address(cfg_dest), .Link_Type(cfg_lt), .SyncWord(cfg_sync),
        .Accept_Broadcast(cfg_bcast), .Frames_Accepted(acc2), .Frames_Dropped(drop2)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    always @(posedge ACLK) begin
        #1;
        case (m_mode)
            1: m_ready = ($urandom_range(0, 2) != 0);
            2: begin
                m_ready = ready_pat[pat_idx];
                pat_idx = (pat_idx + 1) % 4;
            end
            default: m_ready = 1'b1;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Output monitors: every handoff must match the next payload beat the model predicted.
    always @(negedge ACLK) begin
        if (!ARESETN) begin
            prev_hold  = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (prev_hold) checkOutput("hold_stable", {m_valid, m_data, m_keep, m_last}, {1'b1, prev_word});
            if (m_valid && !prev_valid && rise_cyc < 0) rise_cyc = cyc;
            if (m_valid && m_ready) begin
                out1_count++;
                if (exp_q1.size() == 0) checkOutput("out1_unexpected", m_valid, 1'b0);
                else checkOutput("out1_beat", {m_data, m_keep, m_last}, exp_q1.pop_front());
            end
            prev_hold  = m_valid && !m_ready;
            prev_word  = {m_data, m_keep, m_last};
            prev_valid = m_valid;
        end
    end

    always @(negedge ACLK) begin
        if (ARESETN) begin
            checkOutput("s2_ready", s_ready2, 1'b1);
            if (m2_valid) begin
                if (exp_q2.size() == 0) checkOutput("out2_unexpected", m2_valid, 1'b0);
                else checkOutput("out2_beat", {m2_data, m2_keep, m2_last}, exp_q2.pop_front());
            end
        end
    end

    task automatic buildFrame(input logic [47:0] dst, input logic [15:0] lt, input logic [15:0] sw,
                              input int npay);
        logic [7:0] bytes[$];
        int nb;
        for (int i = 5; i >= 0; i--) bytes.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) bytes.push_back(SRC_MAC[8*i +: 8]);
        for (int i = 1; i >= 0; i--) bytes.push_back(lt[8*i +: 8]);
        for (int i = 1; i >= 0; i--) bytes.push_back(sw[8*i +: 8]);
        for (int i = 0; i < npay; i++) bytes.push_back(8'($urandom_range(0, 255)));
        frame_q.delete();
        nb = bytes.size();
        for (int b = 0; b < nb; b += 8) begin
            beat_t bt;
            bt = '0;
            for (int k = 0; k < 8 && b + k < nb; k++) begin
                bt.data[8*k +: 8] = bytes[b+k];
                bt.keep[k] = 1'b1;
            end
            bt.last = (b + 8 >= nb);
            frame_q.push_back(bt);
        end
    endtask

    // Reference decision for a whole frame: both header beats full and not last, fields equal.
    function automatic bit frameAccepted(input bit chk);
        logic [47:0] d;
        logic [15:0] lt, sw;
        if (frame_q.size() < 3) return 1'b0;
        if (frame_q[0].last || frame_q[1].last) return 1'b0;
        if (frame_q[0].keep != 8'hFF || frame_q[1].keep != 8'hFF) return 1'b0;
        d = '0;
        for (int k = 0; k < 6; k++) d = {d[39:0], frame_q[0].data[8*k +: 8]};
        lt = {frame_q[1].data[39:32], frame_q[1].data[47:40]};
        sw = {frame_q[1].data[55:48], frame_q[1].data[63:56]};
        return (d == cfg_dest || (cfg_bcast && d == 48'hFFFF_FFFF_FFFF)) && lt == cfg_lt &&
               (!chk || sw == cfg_sync);
    endfunction

    task automatic predictFrame();
        if (frameAccepted(1'b1)) begin
            exp_acc1++;
            for (int i = 2; i < frame_q.size(); i++) exp_q1.push_back(frame_q[i]);
        end else exp_drop1++;
        if (frameAccepted(1'b0)) begin
            exp_acc2++;
            for (int i = 2; i < frame_q.size(); i++) exp_q2.push_back(frame_q[i]);
        end else exp_drop2++;
    endtask

    task automatic applyStimulus(input beat_t bt);
        bit hs;
        int waited;
        if ($urandom_range(0, 99) < gap_pct) begin
            s_valid = 1'b0;
            @(posedge ACLK); #1;
        end
        s_valid = 1'b1;
        s_data  = bt.data;
        s_keep  = bt.keep;
        s_last  = bt.last;
        waited  = 0;
        do begin
            @(negedge ACLK);
            hs = s_ready;
            if (check_ready_drop) checkOutput("drop_ready", s_ready, 1'b1);
            @(posedge ACLK); #1;
            waited++;
        end while (!hs && waited < 200);
        checkOutput("s_handshake", hs, 1'b1);
    endtask

    task automatic sendFrame();
        check_ready_drop = !frameAccepted(1'b1);
        predictFrame();
        for (int i = 0; i < frame_q.size(); i++) begin
            applyStimulus(frame_q[i]);
            if (i == 2) beat2_cyc = cyc;
        end
        s_valid = 1'b0;
        check_ready_drop = 1'b0;
        @(negedge ACLK);
        checkOutput("acc1", acc1, exp_acc1);
        checkOutput("drop1", drop1, exp_drop1);
        checkOutput("acc2", acc2, exp_acc2);
        checkOutput("drop2", drop2, exp_drop2);
        @(posedge ACLK); #1;
    endtask

    task automatic drainOutputs();
        m_mode = 0;
        for (int i = 0; i < 100 && (exp_q1.size() != 0 || exp_q2.size() != 0); i++) @(negedge ACLK);
        checkOutput("drain1", exp_q1.size(), 0);
        checkOutput("drain2", exp_q2.size(), 0);
        @(posedge ACLK); #1;
    endtask

    initial begin
        cfg_dest = OWN_MAC;
        cfg_lt   = 16'h88B5;
        cfg_sync = 16'hA5A5;
        #12;
        checkOutput("rst_m_valid", m_valid, 1'b0);
        checkOutput("rst_m_word", {m_data, m_keep, m_last}, '0);
        checkOutput("rst_counters", {acc1, drop1}, '0);
        #3 ARESETN = 1'b1;
        @(posedge ACLK); #1;
        checkOutput("rst_s_ready", s_ready, 1'b1);

        // Matching frame, 20 payload bytes -> 3 beats, last keep 0x0F, output right after beat 2.
        rise_cyc = -1;
        out1_count = 0;
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 20);
        sendFrame();
        drainOutputs();
        checkOutput("first_out_latency", rise_cyc - beat2_cyc, 0);
        checkOutput("t1_out_beats", out1_count, 3);
        checkOutput("t1_last_keep", frame_q[frame_q.size()-1].keep, 8'h0F);

        // Wrong destination, then matching frame.
        buildFrame(48'h02_00_00_00_00_02, 16'h88B5, 16'hA5A5, 24);
        sendFrame();
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 13);
        sendFrame();

        // Broadcast with and without Accept_Broadcast; zero sync word only passes CHECK_SYNC=0.
        buildFrame(48'hFFFF_FFFF_FFFF, 16'h88B5, 16'hA5A5, 9);
        sendFrame();
        cfg_bcast = 1'b1;
        buildFrame(48'hFFFF_FFFF_FFFF, 16'h88B5, 16'hA5A5, 9);
        sendFrame();
        cfg_bcast = 1'b0;
        buildFrame(OWN_MAC, 16'h88B5, 16'h0000, 16);
        sendFrame();

        // Runt: single beat with tlast, then header-only, then a clean frame.
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 8);
        frame_q[0].last = 1'b1;
        frame_q = frame_q[0:0];
        sendFrame();
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 0);
        sendFrame();
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 5);
        sendFrame();
        drainOutputs();

        // 8-beat payload under a 1-0-0-1 ready pattern.
        m_mode = 2;
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 64);
        sendFrame();
        drainOutputs();

        // Reset in the middle of the payload; the tail is then parsed as a new frame.
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 48);
        predictFrame();
        for (int i = 0; i < 4; i++) applyStimulus(frame_q[i]);
        s_valid = 1'b0;
        @(posedge ACLK); #2;
        ARESETN = 1'b0;
        #1;
        checkOutput("midrst_m_valid", m_valid, 1'b0);
        checkOutput("midrst_counters", {acc1, drop1, acc2, drop2}, '0);
        exp_q1.delete();
        exp_q2.delete();
        exp_acc1 = '0; exp_drop1 = '0; exp_acc2 = '0; exp_drop2 = '0;
        @(posedge ACLK); @(posedge ACLK); #3;
        ARESETN = 1'b1;
        @(posedge ACLK); #1;
        frame_q = frame_q[4:$];
        sendFrame();
        buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 30);
        sendFrame();
        drainOutputs();

        // Randomized traffic with random ready and input gaps.
        m_mode = 1;
        gap_pct = 30;
        for (int n = 0; n < 60; n++) begin
            int kind;
            int npay;
            kind = $urandom_range(0, 9);
            npay = $urandom_range(1, 40);
            cfg_bcast = 1'($urandom_range(0, 1));
            case (kind)
                5: buildFrame(OWN_MAC ^ 48'h1, 16'h88B5, 16'hA5A5, npay);
                6: buildFrame(OWN_MAC, 16'h0800, 16'hA5A5, npay);
                7: buildFrame(OWN_MAC, 16'h88B5, 16'($urandom_range(0, 65535)), npay);
                8: buildFrame(48'hFFFF_FFFF_FFFF, 16'h88B5, 16'hA5A5, npay);
                9: begin
                    buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, npay);
                    case ($urandom_range(0, 2))
                        0: begin frame_q[0].last = 1'b1; frame_q = frame_q[0:0]; end
                        1: buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, 0);
                        default: frame_q[1].keep = 8'h7F;
                    endcase
                end
                default: buildFrame(OWN_MAC, 16'h88B5, 16'hA5A5, npay);
            endcase
            sendFrame();
        end
        drainOutputs();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
